// File: rtl/sysid_read_arbiter.sv
// rtl/sysid_read_arbiter.sv - boot self-check and round-robin read sharing of the sysid slave
//
// Parameters:
//   READ_LATENCY  extra cycles between driving sys_address and sampling sys_readdata (0..3)
//   EXPECTED_ID   word required at address 0
//   EXPECTED_TS   word required at address 1
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   reqN_valid / reqN_address    read request and word select from requester N
//   reqN_ready                   request accepted this cycle (combinational, IDLE only)
//   respN_valid / respN_data     one-cycle response strobe and held read data
//   sys_address / sys_readdata   sysid slave interface
//   check_done / id_ok / id_mismatch  boot check result, sticky until reset
module sysid_read_arbiter #(
  parameter int          READ_LATENCY = 0,
  parameter logic [31:0] EXPECTED_ID  = 32'd102,
  parameter logic [31:0] EXPECTED_TS  = 32'd1526570516
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_address,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_data,
  input  logic        req1_valid,
  input  logic        req1_address,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_data,
  output logic        sys_address,
  input  logic [31:0] sys_readdata,
  output logic        check_done,
  output logic        id_ok,
  output logic        id_mismatch
);

  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sysid_read_arbiter: READ_LATENCY must be within 0..3");
  end

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  typedef enum logic [1:0] {CHK_ID, CHK_TS, IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        sys_address_q, sys_address_d;
  logic        id_match_q, id_match_d;
  logic        check_done_q, check_done_d;
  logic        id_ok_q, id_ok_d;
  logic        id_mismatch_q, id_mismatch_d;
  logic        resp0_valid_q, resp0_valid_d;
  logic        resp1_valid_q, resp1_valid_d;
  logic [31:0] resp0_data_q, resp0_data_d;
  logic [31:0] resp1_data_q, resp1_data_d;
  logic        gnt0, gnt1;
  logic        phase_end;
  logic        boot_ok;

  // Last cycle of a READ_LATENCY+1 cycle phase: sys_readdata is valid now.
  assign phase_end = (cnt_q == LAT);
  assign boot_ok   = id_match_q & (sys_readdata == EXPECTED_TS);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    sys_address_d = sys_address_q;
    id_match_d    = id_match_q;
    check_done_d  = check_done_q;
    id_ok_d       = id_ok_q;
    id_mismatch_d = id_mismatch_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_data_d  = resp0_data_q;
    resp1_data_d  = resp1_data_q;
    gnt0          = 1'b0;
    gnt1          = 1'b0;

    case (state_q)
      CHK_ID: begin
        sys_address_d = 1'b0;
        if (phase_end) begin
          id_match_d    = (sys_readdata == EXPECTED_ID);
          sys_address_d = 1'b1;  // timestamp word must be on the bus on the first CHK_TS cycle
          cnt_d         = 2'd0;
          state_d       = CHK_TS;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      CHK_TS: begin
        if (phase_end) begin
          check_done_d  = 1'b1;
          id_ok_d       = boot_ok;
          id_mismatch_d = ~boot_ok;
          cnt_d         = 2'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      IDLE: begin
        // On a tie the requester that was not served last wins.
        gnt0 = req0_valid & (~req1_valid | last_grant_q);
        gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
        if (gnt0) begin
          last_grant_d  = 1'b0;
          sys_address_d = req0_address;
          cnt_d         = 2'd0;
          state_d       = BUSY;
        end else if (gnt1) begin
          last_grant_d  = 1'b1;
          sys_address_d = req1_address;
          cnt_d         = 2'd0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (phase_end) begin
          // last_grant identifies the requester owning the read in flight.
          if (last_grant_q) begin
            resp1_valid_d = 1'b1;
            resp1_data_d  = sys_readdata;
          end else begin
            resp0_valid_d = 1'b1;
            resp0_data_d  = sys_readdata;
          end
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = CHK_ID;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= CHK_ID;
      cnt_q         <= 2'd0;
      last_grant_q  <= 1'b1;
      sys_address_q <= 1'b0;
      id_match_q    <= 1'b0;
      check_done_q  <= 1'b0;
      id_ok_q       <= 1'b0;
      id_mismatch_q <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= 32'd0;
      resp1_data_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      sys_address_q <= sys_address_d;
      id_match_q    <= id_match_d;
      check_done_q  <= check_done_d;
      id_ok_q       <= id_ok_d;
      id_mismatch_q <= id_mismatch_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end

  // Ready is gated by reset so that every output reads 0 while reset is held.
  assign req0_ready  = gnt0 & ~reset;
  assign req1_ready  = gnt1 & ~reset;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_data  = resp0_data_q;
  assign resp1_data  = resp1_data_q;
  assign sys_address = sys_address_q;
  assign check_done  = check_done_q;
  assign id_ok       = id_ok_q;
  assign id_mismatch = id_mismatch_q;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// tb/tb_sysid_read_arbiter.sv - directed scoreboard bench for sysid_read_arbiter
module tb_sysid_read_arbiter;

  localparam logic [31:0] ID = 32'd102;
  localparam logic [31:0] TS = 32'd1526570516;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DUT a: READ_LATENCY=0
  logic        a_reset, a_req0_valid, a_req0_address, a_req0_ready, a_resp0_valid;
  logic        a_req1_valid, a_req1_address, a_req1_ready, a_resp1_valid;
  logic [31:0] a_resp0_data, a_resp1_data, a_sys_readdata;
  logic        a_sys_address, a_check_done, a_id_ok, a_id_mismatch;
  logic [31:0] ts_a;

  // DUT b: READ_LATENCY=2
  logic        b_reset, b_req0_valid, b_req0_address, b_req0_ready, b_resp0_valid;
  logic        b_req1_valid, b_req1_address, b_req1_ready, b_resp1_valid;
  logic [31:0] b_resp0_data, b_resp1_data, b_sys_readdata;
  logic        b_sys_address, b_check_done, b_id_ok, b_id_mismatch;

  assign a_sys_readdata = a_sys_address ? ts_a : ID;
  assign b_sys_readdata = b_sys_address ? TS : ID;

  sysid_read_arbiter dut_a (
    .clock(clock), .reset(a_reset),
    .req0_valid(a_req0_valid), .req0_address(a_req0_address), .req0_ready(a_req0_ready),
    .resp0_valid(a_resp0_valid), .resp0_data(a_resp0_data),
    .req1_valid(a_req1_valid), .req1_address(a_req1_address), .req1_ready(a_req1_ready),
    .resp1_valid(a_resp1_valid), .resp1_data(a_resp1_data),
    .sys_address(a_sys_address), .sys_readdata(a_sys_readdata),
    .check_done(a_check_done), .id_ok(a_id_ok), .id_mismatch(a_id_mismatch)
  );

  sysid_read_arbiter #(.READ_LATENCY(2)) dut_b (
    .clock(clock), .reset(b_reset),
    .req0_valid(b_req0_valid), .req0_address(b_req0_address), .req0_ready(b_req0_ready),
    .resp0_valid(b_resp0_valid), .resp0_data(b_resp0_data),
    .req1_valid(b_req1_valid), .req1_address(b_req1_address), .req1_ready(b_req1_ready),
    .resp1_valid(b_resp1_valid), .resp1_data(b_resp1_data),
    .sys_address(b_sys_address), .sys_readdata(b_sys_readdata),
    .check_done(b_check_done), .id_ok(b_id_ok), .id_mismatch(b_id_mismatch)
  );

  typedef struct {
    int          dut;
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   r      = 0;
  int   t      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int d, input int p, input logic addr, input logic [31:0] tsv, input int lat);
    exp_t e;
    e.dut  = d;
    e.port = p;
    e.data = addr ? tsv : ID;
    e.cyc  = cyc + lat + 2;
    sb.push_back(e);
  endtask

  task automatic purge(input int d);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].dut == d) sb.delete(i);
  endtask

  task automatic see(input int d, input int p, input logic v, input logic [31:0] data);
    int idx;
    idx = -1;
    if (v) begin
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].dut == d && sb[i].port == p) idx = i;
      checks++;
      assert (idx >= 0) else begin
        errors++;
        $error("FAIL unexpected_strobe dut%0d port%0d cycle %0d observed=1 expected=0", d, p, cyc);
      end
      if (idx >= 0) begin
        chk($sformatf("resp_data_dut%0d_port%0d", d, p), data, sb[idx].data);
        chk($sformatf("resp_cycle_dut%0d_port%0d", d, p), 32'(cyc), 32'(sb[idx].cyc));
        sb.delete(idx);
      end
    end
  endtask

  // One clock: record acceptances seen before the edge, advance, then check strobes.
  task automatic tick();
    #1;
    if (a_req0_valid && a_req0_ready) push(0, 0, a_req0_address, ts_a, 0);
    if (a_req1_valid && a_req1_ready) push(0, 1, a_req1_address, ts_a, 0);
    if (b_req0_valid && b_req0_ready) push(1, 0, b_req0_address, TS, 2);
    if (b_req1_valid && b_req1_ready) push(1, 1, b_req1_address, TS, 2);
    if (a_reset) purge(0);
    if (b_reset) purge(1);
    @(posedge clock);
    #1;
    cyc++;
    see(0, 0, a_resp0_valid, a_resp0_data);
    see(0, 1, a_resp1_valid, a_resp1_data);
    see(1, 0, b_resp0_valid, b_resp0_data);
    see(1, 1, b_resp1_valid, b_resp1_data);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) tick();
    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; ts_a = TS;
    a_req0_valid = 1'b0; a_req0_address = 1'b0; a_req1_valid = 1'b0; a_req1_address = 1'b0;
    b_req0_valid = 1'b0; b_req0_address = 1'b0; b_req1_valid = 1'b0; b_req1_address = 1'b0;
    @(posedge clock);
    #1;
    a_req0_valid = 1'b1;
    tick();
    tick();
    chk("rst_ready0", a_req0_ready, 0);
    chk("rst_check_done", a_check_done, 0);
    chk("rst_id_ok", a_id_ok, 0);
    chk("rst_id_mismatch", a_id_mismatch, 0);
    chk("rst_sys_address", a_sys_address, 0);
    chk("rst_resp0_valid", a_resp0_valid, 0);
    chk("rst_resp0_data", a_resp0_data, 0);

    // Boot check, L=0; early request ignored
    a_reset = 1'b0; r = cyc;
    #1;
    chk("boot_ready_c0", a_req0_ready, 0);
    tick();
    chk("boot_ready_c1", a_req0_ready, 0);
    chk("boot_done_c1", a_check_done, 0);
    a_req0_valid = 1'b0;
    tick();
    chk("boot_done_c2", a_check_done, 1);
    chk("boot_id_ok", a_id_ok, 1);
    chk("boot_id_mismatch", a_id_mismatch, 0);

    // Round robin with both requesters held valid
    a_req0_valid = 1'b1; a_req0_address = 1'b0;
    a_req1_valid = 1'b1; a_req1_address = 1'b1;
    #1;
    chk("rr_c2_ready0", a_req0_ready, 1);
    chk("rr_c2_ready1", a_req1_ready, 0);
    tick();
    chk("rr_c3_sys_address", a_sys_address, 0);
    chk("rr_c3_ready0", a_req0_ready, 0);
    chk("rr_c3_ready1", a_req1_ready, 0);
    tick();
    chk("rr_c4_ready0", a_req0_ready, 0);
    chk("rr_c4_ready1", a_req1_ready, 1);
    tick();
    chk("rr_c5_sys_address", a_sys_address, 1);
    tick();
    chk("rr_c6_ready0", a_req0_ready, 1);
    chk("rr_c6_ready1", a_req1_ready, 0);
    tick();
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    // One-cycle request while BUSY, dropped before IDLE
    a_req0_valid = 1'b1; a_req0_address = 1'b1;
    #1;
    chk("busy_ready0", a_req0_ready, 0);
    tick();
    a_req0_valid = 1'b0;
    drain();
    chk("hold_resp0_data", a_resp0_data, ID);
    chk("hold_resp1_data", a_resp1_data, TS);
    chk("hold_sys_address", a_sys_address, 0);

    // Reset one cycle after an acceptance
    a_req0_valid = 1'b1; a_req0_address = 1'b1;
    #1;
    chk("mid_ready0", a_req0_ready, 1);
    tick();
    a_req0_valid = 1'b0;
    a_reset = 1'b1;
    tick();
    chk("mid_resp0_valid", a_resp0_valid, 0);
    chk("mid_resp0_data", a_resp0_data, 0);
    chk("mid_resp1_data", a_resp1_data, 0);
    chk("mid_check_done", a_check_done, 0);
    chk("mid_id_ok", a_id_ok, 0);
    chk("mid_sys_address", a_sys_address, 0);
    a_reset = 1'b0; r = cyc;
    tick();
    chk("mid_done_c1", a_check_done, 0);
    tick();
    chk("mid_done_c2", a_check_done, 1);
    chk("mid_id_ok_c2", a_id_ok, 1);

    // Timestamp mismatch still serves requesters
    a_reset = 1'b1; ts_a = 32'd0;
    tick();
    a_reset = 1'b0; r = cyc;
    tick();
    tick();
    chk("mm_check_done", a_check_done, 1);
    chk("mm_id_ok", a_id_ok, 0);
    chk("mm_id_mismatch", a_id_mismatch, 1);
    a_req0_valid = 1'b1; a_req0_address = 1'b0;
    tick();
    a_req0_valid = 1'b0;
    drain();
    chk("mm_resp0_data", a_resp0_data, ID);

    // READ_LATENCY=2: boot and single req1 read
    b_reset = 1'b0; r = cyc;
    while (cyc < r + 5) tick();
    chk("l2_done_c5", b_check_done, 0);
    tick();
    chk("l2_done_c6", b_check_done, 1);
    chk("l2_id_ok", b_id_ok, 1);
    chk("l2_id_mismatch", b_id_mismatch, 0);
    b_req1_valid = 1'b1; b_req1_address = 1'b1;
    #1;
    chk("l2_ready1", b_req1_ready, 1);
    t = cyc;
    tick();
    b_req1_valid = 1'b0;
    chk("l2_sys_address_t1", b_sys_address, 1);
    drain();
    chk("l2_resp1_data", b_resp1_data, TS);
    chk("l2_resp0_data", b_resp0_data, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Sequences and shares the 1-bit-address, 32-bit system-ID slave among two requesters.
- After reset it runs a boot self-check: reads word 0 (ID), then word 1 (timestamp), and compares each against expected parameters.
- After the self-check it arbitrates single-word reads from two requesters, round-robin.
- Sits between the sysid slave and the CPU/debug read paths of the QuadTest system.

Parameters:
- READ_LATENCY, 0, extra cycles between driving sys_address and sampling sys_readdata; legal range 0..3.
- EXPECTED_ID, 102, value required at address 0.
- EXPECTED_TS, 1526570516, value required at address 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 read request.
- req0_address  in  1  requester 0 word select.
- req0_ready  out  1  requester 0 request accepted this cycle.
- resp0_valid  out  1  one-cycle response strobe to requester 0.
- resp0_data  out  32  requester 0 read data.
- req1_valid, req1_address, req1_ready, resp1_valid, resp1_data  same as requester 0, for requester 1.
- sys_address  out  1  address to sysid slave.
- sys_readdata  in  32  data from sysid slave.
- check_done  out  1  boot check complete; sticky until reset.
- id_ok  out  1  both boot words matched; valid when check_done=1.
- id_mismatch  out  1  a boot word differed; valid when check_done=1.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values: all outputs 0 (sys_address=0, ready/valid/data=0, check_done/id_ok/id_mismatch=0). last_grant resets to 1, so requester 0 wins the first tie. State resets to CHK_ID.
- FSM states: CHK_ID, CHK_TS, IDLE, BUSY.
- Phase length: a phase is READ_LATENCY+1 cycles, counted by a wait counter cnt that is cleared on each state entry.
- CHK_ID:
  - Drives sys_address=0.
  - When cnt==READ_LATENCY, samples sys_readdata and latches id_match = (data==EXPECTED_ID).
  - Then goes to CHK_TS.
- CHK_TS:
  - Drives sys_address=1.
  - When cnt==READ_LATENCY, latches ts_match.
  - Next cycle: check_done=1, id_ok=id_match&ts_match, id_mismatch=~id_ok.
  - Goes to IDLE.
  - For L=READ_LATENCY, check_done first reads 1 in cycle 2(L+1) after reset deasserts (cycle 0 is the first non-reset cycle). For L=0 that is cycle 2.
- Blocking during boot: req*_ready=0 in CHK_ID and CHK_TS; requests are ignored, not queued.
- Mismatch does not block service: after a failed check, requesters are still served.
- IDLE grant:
  - req*_ready is combinational and is 1 only in IDLE, for the granted requester.
  - Only one requester valid: it is granted.
  - Both valid: grant the one not equal to last_grant.
  - On grant: update last_grant, register sys_address<=req_address, cnt<=0, go to BUSY.
- BUSY:
  - When cnt==READ_LATENCY, capture sys_readdata into respN_data and set respN_valid=1 for exactly the next cycle.
  - Return to IDLE.
- Request-to-response timing:
  - Acceptance at cycle T gives respN_valid high at cycle T+L+2.
  - The next acceptance can occur at cycle T+L+2, the same cycle as the strobe.
  - Minimum spacing between acceptances is L+2 cycles.
- Hold behaviour:
  - respN_data holds its last value until the next response to that requester.
  - sys_address holds its last value in IDLE.
- Requester rules:
  - A requester may drop valid before ready without effect.
  - A request holding valid across a grant to the other requester waits; it is never lost while asserted.
- Reset mid-operation: aborts BUSY or a check. No response strobe is issued. Flags clear and the boot check restarts.
- Range check: cnt is 2 bits wide. A READ_LATENCY above 3 is a synthesis-time error (generate-time check).

Test Plan:
- Defaults, slave returns 102 at address 0 and 1526570516 at address 1 -> check_done=1 at cycle 2 after reset, id_ok=1, id_mismatch=0; requests earlier than that see ready=0.
- Slave returns 0 at address 1 -> check_done=1, id_ok=0, id_mismatch=1; a later req0 read of address 0 still returns 102 with resp0_valid.
- req0 and req1 both held valid, addresses 0 and 1, from IDLE -> grants alternate req0, req1, req0; resp0_data=102 and resp1_data=1526570516; each resp strobe is exactly 1 cycle; acceptances are spaced 2 cycles apart.
- READ_LATENCY=2, single req1 read of address 1 accepted at cycle T -> resp1_valid only at T+4 with 1526570516; sys_address=1 from T+1.
- Reset asserted 1 cycle after a req0 acceptance -> no resp0_valid; all outputs 0; boot check reruns and check_done rises at cycle 2 after deassertion.
- req0 valid for one cycle while the FSM is in BUSY, then dropped -> no acceptance, no response, FSM unaffected.
